// File: rtl/cache_refill_arbiter_pkg.sv
// cache_refill_pkg
// Shared definitions for the cache refill arbiter and its benches:
//   - FSM state encoding (IDLE, REQ, BURST, WAIT_DONE)
//   - owner encoding (OWN_IC = 0, OWN_DC = 1)
//   - helpers that derive the beat count and line offset width
package cache_refill_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_BURST     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // Beats per line refill.
  function automatic int calc_beats(input int line_size, input int data_length);
    return line_size / (data_length / 8);
  endfunction

  // Byte-offset bits inside a line.
  function automatic int calc_offset_bits(input int line_size);
    return $clog2(line_size);
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// cache_refill_arbiter_if
// Bundles every non-clock signal of the refill arbiter.
//   master : arbiter view (receives misses/beats, drives mem_req and refill streams)
//   slave  : environment view (caches + memory)
// Signals:
//   flush                      pipeline flush
//   ic_/dc_miss, ic_/dc_addr   level miss requests and miss addresses
//   ic_/dc_refill_valid/_data  beat stream toward each cache
//   ic_/dc_refill_complete     cache reports line written
//   mem_req/mem_addr/mem_ack   memory read request handshake
//   mem_rvalid/mem_rdata       memory read beats
//   busy                       arbiter not idle
interface cache_refill_arbiter_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
);
  logic                   flush;
  logic                   ic_miss;
  logic                   dc_miss;
  logic [ADDR_WIDTH-1:0]  ic_addr;
  logic [ADDR_WIDTH-1:0]  dc_addr;
  logic                   ic_refill_valid;
  logic                   dc_refill_valid;
  logic [DATA_LENGTH-1:0] ic_refill_data;
  logic [DATA_LENGTH-1:0] dc_refill_data;
  logic                   ic_refill_complete;
  logic                   dc_refill_complete;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;
  logic                   mem_rvalid;
  logic [DATA_LENGTH-1:0] mem_rdata;
  logic                   busy;

  modport master (
    input  flush, ic_miss, dc_miss, ic_addr, dc_addr,
    input  ic_refill_complete, dc_refill_complete,
    input  mem_ack, mem_rvalid, mem_rdata,
    output ic_refill_valid, dc_refill_valid, ic_refill_data, dc_refill_data,
    output mem_req, mem_addr, busy
  );

  modport slave (
    output flush, ic_miss, dc_miss, ic_addr, dc_addr,
    output ic_refill_complete, dc_refill_complete,
    output mem_ack, mem_rvalid, mem_rdata,
    input  ic_refill_valid, dc_refill_valid, ic_refill_data, dc_refill_data,
    input  mem_req, mem_addr, busy
  );
endinterface

// File: rtl/cache_refill_arbiter_rr_picker.sv
// refill_rr_picker
// Two-requester round-robin picker, purely combinational.
//   req[1:0]    pending requests, indexed by owner encoding
//   last_grant  owner served most recently
//   grant       chosen owner (meaningful when valid)
//   valid       at least one request pending
module refill_rr_picker
  import cache_refill_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);
  always_comb begin
    valid = |req;
    grant = OWN_IC;
    if (&req)             grant = ~last_grant;  // tie: whoever was not served last
    else if (req[OWN_DC]) grant = OWN_DC;
  end
endmodule

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
// Shares one memory read port between the I-cache and D-cache miss paths.
// A granted miss becomes a line-aligned memory read; returned beats are
// forwarded to the owner one cycle later, then the arbiter waits for the
// owner's refill_complete before serving the next miss.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  cache_refill_arbiter_if.master (misses, refill streams, memory port, busy)
module cache_refill_arbiter
  import cache_refill_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int LINE_SIZE   = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_refill_arbiter_if.master  bus
);
  localparam int BEATS       = calc_beats(LINE_SIZE, DATA_LENGTH);
  localparam int OFFSET_BITS = calc_offset_bits(LINE_SIZE);
  localparam int CNT_W       = $clog2(BEATS) + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  typedef struct packed {
    logic                  owner;
    logic [ADDR_WIDTH-1:0] line_addr;
  } grant_t;

  logic [1:0]                  state;
  grant_t                      cur;
  logic                        last_grant;
  logic                        drain;
  logic [CNT_W-1:0]            cnt;
  logic [1:0]                  refill_valid;
  logic [1:0][DATA_LENGTH-1:0] refill_data;

  logic [1:0]            miss;
  logic [1:0]            complete;
  logic                  pick;
  logic                  pick_valid;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  last_beat;
  logic                  eff_drain;

  assign miss     = {bus.dc_miss, bus.ic_miss};
  assign complete = {bus.dc_refill_complete, bus.ic_refill_complete};

  refill_rr_picker u_pick (
    .req        (miss),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign pick_addr = (pick == OWN_DC) ? bus.dc_addr : bus.ic_addr;
  assign last_beat = bus.mem_rvalid && (cnt == CNT_W'(BEATS - 1));
  // A flush arriving mid-burst suppresses forwarding from that very beat on.
  assign eff_drain = drain | bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cur          <= '0;
      last_grant   <= OWN_DC;
      drain        <= 1'b0;
      cnt          <= '0;
      refill_valid <= '0;
      refill_data  <= '0;
    end else begin
      refill_valid <= '0;
      case (state)
        S_IDLE: begin
          if (!bus.flush && pick_valid) begin
            cur.owner     <= pick;
            cur.line_addr <= pick_addr & LINE_MASK;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            // Request is committed to memory; a flush here can only drain it.
            cnt   <= '0;
            drain <= bus.flush;
            state <= S_BURST;
          end else if (bus.flush) begin
            last_grant <= cur.owner;
            state      <= S_IDLE;
          end
        end
        S_BURST: begin
          if (bus.flush) drain <= 1'b1;
          if (bus.mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (!eff_drain) begin
              refill_valid[cur.owner] <= 1'b1;
              refill_data[cur.owner]  <= bus.mem_rdata;
            end
            if (last_beat) begin
              if (eff_drain) begin
                drain      <= 1'b0;
                last_grant <= cur.owner;
                state      <= S_IDLE;
              end else begin
                state <= S_WAIT_DONE;
              end
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.flush || complete[cur.owner]) begin
            last_grant <= cur.owner;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req         = (state == S_REQ);
  assign bus.mem_addr        = cur.line_addr;
  assign bus.busy            = (state != S_IDLE);
  assign bus.ic_refill_valid = refill_valid[OWN_IC];
  assign bus.dc_refill_valid = refill_valid[OWN_DC];
  assign bus.ic_refill_data  = refill_data[OWN_IC];
  assign bus.dc_refill_data  = refill_data[OWN_DC];

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;
  import cache_refill_pkg::*;

  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic m_last;  // reference model: owner served most recently

  cache_refill_arbiter_if #(.DATA_LENGTH(32), .ADDR_WIDTH(32)) bus ();

  cache_refill_arbiter #(.DATA_LENGTH(32), .LINE_SIZE(64), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  function automatic logic own_valid(input logic o);
    return o ? bus.dc_refill_valid : bus.ic_refill_valid;
  endfunction

  function automatic logic oth_valid(input logic o);
    return o ? bus.ic_refill_valid : bus.dc_refill_valid;
  endfunction

  function automatic logic [31:0] own_data(input logic o);
    return o ? bus.dc_refill_data : bus.ic_refill_data;
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the one not served last.
  function automatic logic model_pick(input logic ic, input logic dc);
    if (ic && dc) return (m_last == OWN_IC) ? OWN_DC : OWN_IC;
    return dc ? OWN_DC : OWN_IC;
  endfunction

  task automatic set_miss(input logic o, input logic v, input logic [31:0] a);
    if (o) begin bus.dc_miss = v; bus.dc_addr = a; end
    else   begin bus.ic_miss = v; bus.ic_addr = a; end
  endtask

  task automatic set_complete(input logic o, input logic v);
    if (o) bus.dc_refill_complete = v;
    else   bus.ic_refill_complete = v;
  endtask

  // Serves one refill for owner o at address a. gap: 0 none, 1 every other
  // cycle, 2 random. noise injects inputs that must be ignored. fl ends the
  // WAIT_DONE phase with a flush instead of refill_complete.
  task automatic run_refill(input string nm, input logic o, input logic [31:0] a,
                            input int ack_dly, input int gap, input bit noise, input bit fl);
    int t;
    int ng;
    logic [31:0] d;
    logic [31:0] ea;
    ea = line_of(a);
    t  = 0;
    while (bus.mem_req !== 1'b1 && t < 20) begin tick(); t++; end
    n_chk++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_timeout: mem_req=%b want 1", nm, bus.mem_req);
      return;
    end
    n_chk++;
    if (bus.mem_addr !== ea) begin
      n_fail++;
      $display("FAIL %s mem_addr: got %h want %h", nm, bus.mem_addr, ea);
    end
    for (int i = 0; i < ack_dly; i++) begin
      bus.mem_rvalid = noise;
      bus.mem_rdata  = $urandom;
      tick();
      n_chk++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== ea || bus.ic_refill_valid !== 1'b0 ||
          bus.dc_refill_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req_hold: req=%b addr=%h ivld=%b dvld=%b want 1 %h 0 0", nm,
                 bus.mem_req, bus.mem_addr, bus.ic_refill_valid, bus.dc_refill_valid, ea);
      end
    end
    bus.mem_ack    = 1'b1;
    bus.mem_rvalid = noise;
    tick();
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1 || bus.ic_refill_valid !== 1'b0 ||
        bus.dc_refill_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_ack: req=%b busy=%b ivld=%b dvld=%b want 0 1 0 0", nm,
               bus.mem_req, bus.busy, bus.ic_refill_valid, bus.dc_refill_valid);
    end
    for (int b = 0; b < BEATS; b++) begin
      ng = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        if (noise) begin set_complete(o, 1'b1); set_complete(!o, 1'b1); end
        tick();
        set_complete(o, 1'b0);
        set_complete(!o, 1'b0);
        n_chk++;
        if (bus.ic_refill_valid !== 1'b0 || bus.dc_refill_valid !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s gap%0d: ivld=%b dvld=%b busy=%b want 0 0 1", nm, b,
                   bus.ic_refill_valid, bus.dc_refill_valid, bus.busy);
        end
      end
      d              = $urandom;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      n_chk++;
      if (own_valid(o) !== 1'b1 || own_data(o) !== d || oth_valid(o) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat%0d: vld=%b data=%h other_vld=%b want 1 %h 0", nm, b,
                 own_valid(o), own_data(o), oth_valid(o), d);
      end
    end
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_done_busy: got %b want 1", nm, bus.busy);
    end
    t = $urandom_range(0, 2);
    for (int i = 0; i < t; i++) begin
      if (noise) set_complete(!o, 1'b1);
      bus.mem_rvalid = noise;
      tick();
      set_complete(!o, 1'b0);
      bus.mem_rvalid = 1'b0;
      n_chk++;
      if (bus.busy !== 1'b1 || bus.ic_refill_valid !== 1'b0 || bus.dc_refill_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait_hold: busy=%b ivld=%b dvld=%b want 1 0 0", nm,
                 bus.busy, bus.ic_refill_valid, bus.dc_refill_valid);
      end
    end
    if (fl) bus.flush = 1'b1;
    else    set_complete(o, 1'b1);
    set_miss(o, 1'b0, a);
    tick();
    bus.flush = 1'b0;
    set_complete(o, 1'b0);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_idle: busy=%b req=%b want 0 0", nm, bus.busy, bus.mem_req);
    end
    m_last = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 0; bus.ic_miss = 0; bus.dc_miss = 0; bus.ic_addr = 0; bus.dc_addr = 0;
    bus.ic_refill_complete = 0; bus.dc_refill_complete = 0;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (3) tick();
    n_chk++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset mem_req: got %b want 0", bus.mem_req); end
    n_chk++;
    if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
    n_chk++;
    if (bus.ic_refill_valid !== 1'b0 || bus.dc_refill_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset valid: got %b%b want 00", bus.ic_refill_valid, bus.dc_refill_valid);
    end
    n_chk++;
    if (bus.ic_refill_data !== 32'h0 || bus.dc_refill_data !== 32'h0) begin
      n_fail++; $display("FAIL reset data: got %h %h want 0 0", bus.ic_refill_data, bus.dc_refill_data);
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    rst    = 1'b0;
    m_last = OWN_DC;
  endtask

  task automatic test_tie();
    logic o;
    set_miss(OWN_IC, 1'b1, 32'h0000_2000);
    set_miss(OWN_DC, 1'b1, 32'h0000_8040);
    o = model_pick(1'b1, 1'b1);
    tick();
    n_chk++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL tie req_latency: got %b want 1", bus.mem_req); end
    run_refill("tie_first", o, (o == OWN_DC) ? 32'h0000_8040 : 32'h0000_2000, 0, 0, 0, 0);
    // IC asks again while DC is still pending: a fresh tie.
    set_miss(OWN_IC, 1'b1, 32'h0000_2100);
    o = model_pick(1'b1, 1'b1);
    run_refill("tie_second", o, (o == OWN_DC) ? 32'h0000_8040 : 32'h0000_2100, 0, 0, 0, 0);
    run_refill("tie_third", !o, (o == OWN_DC) ? 32'h0000_2100 : 32'h0000_8040, 0, 0, 0, 0);
  endtask

  task automatic test_ic_single();
    set_miss(OWN_IC, 1'b1, 32'h0000_1004);
    tick();
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL ic_single req: req=%b addr=%h want 1 00001000", bus.mem_req, bus.mem_addr);
    end
    run_refill("ic_single", OWN_IC, 32'h0000_1004, 0, 0, 0, 0);
  endtask

  task automatic test_gapped();
    run_gapped_one();
  endtask

  task automatic run_gapped_one();
    logic [31:0] a;
    a = $urandom;
    set_miss(OWN_DC, 1'b1, a);
    run_refill("gapped", OWN_DC, a, 5, 1, 0, 0);
  endtask

  task automatic test_ignored();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      bus.dc_refill_complete = 1'b1;
      tick();
      n_chk++;
      if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.ic_refill_valid !== 1'b0 ||
          bus.dc_refill_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_noise: req=%b busy=%b ivld=%b dvld=%b want 0 0 0 0",
                 bus.mem_req, bus.busy, bus.ic_refill_valid, bus.dc_refill_valid);
      end
    end
    bus.mem_rvalid = 1'b0;
    bus.dc_refill_complete = 1'b0;
    a = $urandom;
    set_miss(OWN_IC, 1'b1, a);
    run_refill("noise", OWN_IC, a, 2, 2, 1, 0);
  endtask

  task automatic test_flush_req();
    set_miss(OWN_IC, 1'b1, 32'h0000_3010);
    tick();
    n_chk++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_req pre: req=%b want 1", bus.mem_req); end
    bus.flush = 1'b1;
    set_miss(OWN_IC, 1'b0, 32'h0000_3010);
    tick();
    bus.flush = 1'b0;
    n_chk++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_req idle: req=%b busy=%b want 0 0", bus.mem_req, bus.busy);
    end
    m_last = OWN_IC;
    tick();
    n_chk++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req stay: req=%b want 0", bus.mem_req); end
  endtask

  // fa = last beat index still forwarded; -1 flushes in the ack cycle.
  task automatic test_flush_burst(input string nm, input logic o, input int fa);
    logic [31:0] a;
    logic [31:0] d;
    logic        ex;
    a = $urandom;
    set_miss(o, 1'b1, a);
    tick();
    n_chk++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL %s pre_req: req=%b want 1", nm, bus.mem_req); end
    bus.mem_ack = 1'b1;
    if (fa < 0) begin bus.flush = 1'b1; set_miss(o, 1'b0, a); end
    tick();
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (fa >= 0 && b == fa + 1) begin
        bus.flush = 1'b1;
        set_miss(o, 1'b0, a);
        tick();
        bus.flush = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1 || own_valid(o) !== 1'b0) begin
          n_fail++; $display("FAIL %s flush_cycle: busy=%b vld=%b want 1 0", nm, bus.busy, own_valid(o));
        end
      end
      d = $urandom;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d;
      tick();
      bus.mem_rvalid = 1'b0;
      ex = (b <= fa);
      n_chk++;
      if (own_valid(o) !== ex || oth_valid(o) !== 1'b0 || (ex && own_data(o) !== d)) begin
        n_fail++;
        $display("FAIL %s beat%0d: vld=%b data=%h other=%b want %b %h 0", nm, b,
                 own_valid(o), own_data(o), oth_valid(o), ex, d);
      end
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s drain_exit: busy=%b req=%b want 0 0", nm, bus.busy, bus.mem_req);
    end
    m_last = o;
  endtask

  task automatic test_random();
    int          pat;
    logic [31:0] ai;
    logic [31:0] ad;
    logic        o;
    for (int it = 0; it < 10; it++) begin
      pat = $urandom_range(1, 3);
      ai  = $urandom;
      ad  = $urandom;
      if (pat[0]) set_miss(OWN_IC, 1'b1, ai);
      if (pat[1]) set_miss(OWN_DC, 1'b1, ad);
      o = model_pick(pat[0], pat[1]);
      run_refill($sformatf("rand%0d_a", it), o, o ? ad : ai, $urandom_range(0, 3), 2,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if (pat == 3)
        run_refill($sformatf("rand%0d_b", it), !o, o ? ai : ad, $urandom_range(0, 3), 2,
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid();
    logic o;
    set_miss(OWN_DC, 1'b1, 32'h0000_5000);
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      tick();
    end
    rst = 1'b1;
    bus.mem_rdata = $urandom;
    set_miss(OWN_DC, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.ic_refill_valid !== 1'b0 || bus.dc_refill_valid !== 1'b0 ||
        bus.ic_refill_data !== 32'h0 || bus.dc_refill_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: busy=%b req=%b addr=%h vld=%b%b data=%h %h want all 0",
               bus.busy, bus.mem_req, bus.mem_addr, bus.ic_refill_valid, bus.dc_refill_valid,
               bus.ic_refill_data, bus.dc_refill_data);
    end
    m_last = OWN_DC;
    set_miss(OWN_IC, 1'b1, 32'h0000_6004);
    set_miss(OWN_DC, 1'b1, 32'h0000_7008);
    o = model_pick(1'b1, 1'b1);
    run_refill("post_rst_a", o, o ? 32'h0000_7008 : 32'h0000_6004, 1, 0, 0, 0);
    run_refill("post_rst_b", !o, o ? 32'h0000_6004 : 32'h0000_7008, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_ic_single();
    test_gapped();
    test_ignored();
    test_flush_req();
    test_flush_burst("flush_b4", OWN_IC, 4);
    test_flush_burst("flush_ack", OWN_DC, -1);
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
